// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: instruction width, PC step and the
// fetch-queue entry layout used at the default 32-bit address width.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_INCR  = 4;
  localparam int unsigned XLEN_DEF = 32;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus bundle: IMEM request/ack channel plus the decode-side
// valid/ready channel. master = fetch unit, slave = IMEM/decode side.
interface mips_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  import mips_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_pc4;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_ack, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/mips_sync_fifo.sv
// Generic synchronous FIFO with flush. DEPTH must be a power of 2 so the
// pointers wrap naturally. Push into a full FIFO and pop from an empty FIFO
// are ignored; flush wins over both.
module mips_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Next pointer/occupancy and storage write.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rptr_q];
  assign count    = count_q;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled MIPS instruction fetch: fetch PC, IMEM valid/ack requests and a
// small queue of {pc, instr} ahead of decode. Redirects flush the queue.
// Optional build macro MIPS_FETCH_BYPASS_EN: when the queue is empty and a
// fetch coincides with decode ready, the word goes straight to decode.
module mips_fetch_unit import mips_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  mips_fetch_unit_if.master        bus,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     misalign
);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  // Same shape as fetch_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            misalign_q, misalign_d;
  entry_t          last_q, last_d;
  entry_t          push_entry, head_entry, out_entry;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            xfer, push, pop, bypass, out_valid;

  mips_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Request only depends on occupancy and reset, never on ack/ready.
  assign bus.imem_req  = !rst && !fifo_full;
  assign bus.imem_addr = fpc_q;

  // Transfer/bypass decisions, output selection and next fetch PC.
  always_comb begin
    xfer   = bus.imem_req && bus.imem_ack;
    bypass = 1'b0;
`ifdef MIPS_FETCH_BYPASS_EN
    bypass = xfer && bus.out_ready && (fifo_count == '0) && !redirect_valid;
`endif
    push       = xfer && !redirect_valid && !bypass;
    pop        = !fifo_empty && bus.out_ready;
    push_entry = '{pc: fpc_q, instr: bus.imem_rdata};
    out_valid  = !fifo_empty || bypass;
    if (bypass) begin
      out_entry = push_entry;
    end else if (!fifo_empty) begin
      out_entry = head_entry;
    end else begin
      out_entry = last_q;
    end
    // Decode outputs keep the last presented entry while the queue is empty.
    last_d = out_valid ? out_entry : last_q;
    fpc_d  = fpc_q;
    if (redirect_valid) begin
      fpc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (xfer) begin
      fpc_d = fpc_q + XLEN'(PC_INCR);
    end
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  // Fetch PC, misalign pulse and held-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      misalign_q <= 1'b0;
      last_q     <= '0;
    end else begin
      fpc_q      <= fpc_d;
      misalign_q <= misalign_d;
      last_q     <= last_d;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_entry.instr;
  assign bus.out_pc    = out_entry.pc;
  assign bus.out_pc4   = out_entry.pc + XLEN'(PC_INCR);
  assign misalign      = misalign_q;

endmodule
